// File: rtl/stream_source.sv
`default_nettype none
// ============================================================================
//  Module      : stream_source
//  Description : Frame-oriented valid/ready stream generator. A start in IDLE
//                with a non-zero len emits len beats. The first beat is seed.
//                Each later beat is seed+k, or an LFSR step of the previous
//                beat when STREAM_SOURCE_LFSR_EN is defined (requires N=32).
//                m_last marks the final beat. done pulses for one cycle at
//                frame end. stall_cnt counts valid-but-not-ready cycles.
//  Ports       : clk, rst_n (async, active-low)
//                start, len[LEN_W], seed[N]  - frame request (IDLE only)
//                m_ready                     - downstream ready
//                m_valid, m_data[N], m_last  - registered stream outputs
//                busy, done, stall_cnt[32]   - status
//  Config      : `define STREAM_SOURCE_LFSR_EN for LFSR data sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_source #(
    parameter int N     = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [N-1:0]     seed,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [N-1:0]     m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      c_sat     = 32'hFFFF_FFFF;

    state_t           r_state,     w_state_nxt;
    logic             r_valid,     w_valid_nxt;
    logic [N-1:0]     r_data,      w_data_nxt;
    logic             r_last,      w_last_nxt;
    logic             r_done,      w_done_nxt;
    logic [31:0]      r_stall_cnt, w_stall_nxt;
    // Beats still to be presented after the one currently on the bus.
    logic [LEN_W-1:0] r_remain,    w_remain_nxt;

    logic [N-1:0]     w_first_word;
    logic [N-1:0]     w_step_word;

`ifdef STREAM_SOURCE_LFSR_EN
    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};
    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign w_first_word = (seed == '0) ? c_one : seed;
    // Recurrence s[n+32] = s[n+22]^s[n+2]^s[n+1]^s[n] with the newest bit
    // entering at bit 0, so the oldest bit s[n] sits at bit 31.
    assign w_step_word  = {r_data[N-2:0],
                           r_data[31] ^ r_data[30] ^ r_data[29] ^ r_data[9]};
`else
    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};
    assign w_first_word = seed;
    assign w_step_word  = r_data + c_one;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_stall_cnt <= '0;
            r_remain    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_data      <= w_data_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_remain    <= w_remain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_data_nxt   = r_data;
        w_last_nxt   = r_last;
        w_done_nxt   = 1'b0;
        w_stall_nxt  = r_stall_cnt;
        w_remain_nxt = r_remain;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stall_nxt = '0;
                    if (len != '0) begin
                        w_state_nxt  = SEND;
                        w_valid_nxt  = 1'b1;
                        w_data_nxt   = w_first_word;
                        w_last_nxt   = (len == c_len_one);
                        w_remain_nxt = len - c_len_one;
                    end else begin
                        // Empty frame: nothing to send, just report completion.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                if (r_valid && m_ready) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Next beat goes out immediately: no bubble.
                        w_data_nxt   = w_step_word;
                        w_last_nxt   = (r_remain == c_len_one);
                        w_remain_nxt = r_remain - c_len_one;
                    end
                end else if (r_valid && !m_ready) begin
                    if (r_stall_cnt != c_sat) begin
                        w_stall_nxt = r_stall_cnt + 32'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m_valid   = r_valid;
    assign m_data    = r_data;
    assign m_last    = r_last;
    assign busy      = (r_state == SEND);
    assign done      = r_done;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_source
//  Description : Self-checking bench for stream_source. A reference model
//                computes each beat from the seed and the beat index.
//                Directed frames cover back-to-back and stalled transfers,
//                empty frames, start while busy, and reset mid-frame. These
//                are followed by randomized frames with random m_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_source;

    localparam int N     = 32;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     seed;
    logic             m_ready;
    logic             m_valid;
    logic [N-1:0]     m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic [31:0]      stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_source #(
        .N     (N),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .seed      (seed),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected value of beat k of a frame started with seed s.
    function automatic logic [N-1:0] model_beat(input logic [N-1:0] s, input int k);
`ifdef STREAM_SOURCE_LFSR_EN
        logic [31:0] v;
        v = (s == 32'd0) ? 32'd1 : s;
        // s[n+32] = s[n] ^ s[n+1] ^ s[n+2] ^ s[n+22]; newest bit at bit 0.
        for (int i = 0; i < k; i++) begin
            v = {v[30:0], v[31] ^ v[30] ^ v[29] ^ v[9]};
        end
        return v;
`else
        return s + N'(k);
`endif
    endfunction

    // Issues start at the current negedge and follows the frame to its done
    // pulse, returning at the negedge where done is observed.
    task automatic run_frame(input int flen, input logic [N-1:0] fseed, input bit rnd,
                             input int stall_beat, input int stall_n, input int inject_at);
        int k;
        int stalls;
        int sb;
        int cyc;
        bit rdy;
        k = 0; stalls = 0; sb = 0; cyc = 0;
        start   = 1'b1;
        len     = flen[LEN_W-1:0];
        seed    = fseed;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        len   = LEN_W'($urandom);
        seed  = $urandom;
        if (flen == 0) begin
            check("empty_done",  64'(done),      64'd1);
            check("empty_valid", 64'(m_valid),   64'd0);
            check("empty_busy",  64'(busy),      64'd0);
            check("empty_stall", 64'(stall_cnt), 64'd0);
            return;
        end
        while (k < flen) begin
            if (cyc > 500) begin
                check("frame_timeout", 64'(k), 64'(flen));
                break;
            end
            check("valid",     64'(m_valid),   64'd1);
            check("data",      64'(m_data),    64'(model_beat(fseed, k)));
            check("last",      64'(m_last),    64'(k == flen - 1));
            check("busy",      64'(busy),      64'd1);
            check("done_mid",  64'(done),      64'd0);
            check("stall_cnt", 64'(stall_cnt), 64'(stalls));
            // A start while busy carries junk len/seed and must be ignored.
            start = (cyc == inject_at);
            if (k == stall_beat && sb < stall_n) begin
                rdy = 1'b0;
                sb++;
            end else if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            m_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
            else     stalls++;
        end
        start = 1'b0;
        check("end_done",  64'(done),      64'd1);
        check("end_valid", 64'(m_valid),   64'd0);
        check("end_last",  64'(m_last),    64'd0);
        check("end_busy",  64'(busy),      64'd0);
        check("end_stall", 64'(stall_cnt), 64'(stalls));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        len     = '0;
        seed    = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(m_valid),   64'd0);
        check("rst_data",  64'(m_data),    64'd0);
        check("rst_last",  64'(m_last),    64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 64'(m_valid), 64'd0);

        // Back-to-back frame with m_ready held high.
        run_frame(4, 32'h10, 1'b0, -1, 0, -1);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);

        // Data wrap with two stall cycles on beat 1.
        run_frame(3, 32'hFFFF_FFFF, 1'b0, 1, 2, -1);
        @(negedge clk);
        check("done_width2", 64'(done),      64'd0);
        check("stall_hold",  64'(stall_cnt), 64'd2);

        // Empty frame clears stall_cnt and only pulses done.
        run_frame(0, 32'h1234, 1'b0, -1, 0, -1);
        @(negedge clk);
        check("empty_after_done",  64'(done),    64'd0);
        check("empty_after_valid", 64'(m_valid), 64'd0);
        check("empty_after_busy",  64'(busy),    64'd0);

        // Start while busy is ignored; start coincident with done is accepted.
        run_frame(3, 32'hA0, 1'b0, -1, 0, 1);
        run_frame(2, 32'h55, 1'b0, -1, 0, -1);
        @(negedge clk);

        // Reset mid-frame while beat 2 of an 8-beat frame is presented.
        start   = 1'b1;
        len     = LEN_W'(8);
        seed    = 32'h200;
        m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_data", 64'(m_data), 64'(model_beat(32'h200, 2)));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(m_valid),   64'd0);
        check("async_rst_data",  64'(m_data),    64'd0);
        check("async_rst_last",  64'(m_last),    64'd0);
        check("async_rst_busy",  64'(busy),      64'd0);
        check("async_rst_done",  64'(done),      64'd0);
        check("async_rst_stall", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done",  64'(done),    64'd0);
        check("post_rst_valid", 64'(m_valid), 64'd0);
        check("post_rst_busy",  64'(busy),    64'd0);
        run_frame(2, 32'h77, 1'b0, -1, 0, -1);
        @(negedge clk);

        // Longest frame the beat counter allows, with random back-pressure.
        run_frame((1 << LEN_W) - 1, $urandom, 1'b1, -1, 0, -1);
        @(negedge clk);

        // Random frames, sometimes back-to-back with done.
        for (int f = 0; f < 10; f++) begin
            run_frame($urandom_range(1, (1 << LEN_W) - 1), $urandom, 1'b1, -1, 0, -1);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("rand_done_width", 64'(done), 64'd0);
            end
        end

`ifdef STREAM_SOURCE_LFSR_EN
        @(negedge clk);
        run_frame(2, 32'h0, 1'b0, -1, 0, -1);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
